// File: rtl/cmsdk_apb4_eg_pkg.sv
// Shared types and helpers for the APB4 wait-state slave front-end.
package cmsdk_apb4_eg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The two supported bus data widths
  localparam int unsigned DW_NARROW = 32;
  localparam int unsigned DW_WIDE   = 64;

  // Number of low address bits that must be zero for a word-aligned access
  function automatic int unsigned addr_lsbs(input int unsigned dw);
    return (dw == DW_WIDE) ? 3 : ((dw == DW_NARROW) ? 2 : 2);
  endfunction

endpackage

// File: rtl/cmsdk_apb4_eg_slave_ws_interface_if.sv
// APB4 bus bundle between fabric (master) and the slave front-end (slave).
interface cmsdk_apb4_eg_slave_ws_interface_if #(
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned DATAWIDTH = 32
);
  logic                   psel;
  logic [ADDRWIDTH-1:0]   paddr;
  logic                   penable;
  logic                   pwrite;
  logic [DATAWIDTH-1:0]   pwdata;
  logic [DATAWIDTH/8-1:0] pstrb;
  logic [2:0]             pprot;
  logic [DATAWIDTH-1:0]   prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, paddr, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, paddr, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/cmsdk_apb4_eg_timeout_cnt.sv
// Request-phase cycle counter; done flags the last allowed wait cycle.
module cmsdk_apb4_eg_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // clear has priority so a fresh request always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/cmsdk_apb4_eg_slave_ws_interface.sv
// APB4 slave front-end: turns APB transfers into a held register request with
// wait states, timeout and decode/protection error responses.
module cmsdk_apb4_eg_slave_ws_interface
  import cmsdk_apb4_eg_pkg::*;
#(
  parameter int unsigned ADDRWIDTH  = 12,
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned ADDR_MAX   = 'hFFF,
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          PROT_CHECK = 1'b1
) (
  input  logic                   pclk,
  input  logic                   presetn,
  cmsdk_apb4_eg_slave_ws_interface_if.slave apb,
  output logic [ADDRWIDTH-1:0]   addr,
  output logic                   read_en,
  output logic                   write_en,
  output logic [DATAWIDTH/8-1:0] byte_strobe,
  output logic [DATAWIDTH-1:0]   wdata,
  input  logic [DATAWIDTH-1:0]   rdata,
  input  logic                   reg_ready,
  input  logic                   reg_err
);
  localparam int unsigned LSBS = addr_lsbs(DATAWIDTH);

  state_t                 state_q, state_d;
  logic                   is_write_q;
  logic                   setup, decode_err;
  logic                   cnt_clear, cnt_en, cnt_done;
  logic                   read_en_d, write_en_d, pready_d, pslverr_d;
  logic [DATAWIDTH-1:0]   prdata_d;
  logic                   unused_prot;

  assign setup = apb.psel & ~apb.penable;

  // Rejected transfers never reach the register side
  assign decode_err = (32'(apb.paddr) > ADDR_MAX)
                    | (apb.paddr[LSBS-1:0] != '0)
                    | (PROT_CHECK & apb.pwrite & apb.pprot[1]);

  assign cnt_clear   = (state_q == ST_IDLE) & setup & ~decode_err;
  assign cnt_en      = (state_q == ST_REQ);
  assign unused_prot = ^{apb.pprot[2], apb.pprot[0]};

  cmsdk_apb4_eg_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk    (pclk),
    .rst_n  (presetn),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .done   (cnt_done)
  );

  // State register plus the registered request/response outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      read_en     <= 1'b0;
      write_en    <= 1'b0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
    end else begin
      state_q     <= state_d;
      read_en     <= read_en_d;
      write_en    <= write_en_d;
      apb.pready  <= pready_d;
      apb.pslverr <= pslverr_d;
      apb.prdata  <= prdata_d;
    end
  end

  // Capture the transfer attributes at the setup phase
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr        <= '0;
      wdata       <= '0;
      byte_strobe <= '0;
      is_write_q  <= 1'b0;
    end else if ((state_q == ST_IDLE) && setup) begin
      addr        <= apb.paddr;
      wdata       <= apb.pwdata;
      byte_strobe <= apb.pstrb;
      is_write_q  <= apb.pwrite;
    end
  end

  // Next-state decode; a dropped psel abandons the request silently
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (setup) state_d = decode_err ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (!apb.psel)                 state_d = ST_IDLE;
        else if (reg_ready | cnt_done) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; response fields default to zero
  always_comb begin
    read_en_d  = read_en;
    write_en_d = write_en;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    case (state_q)
      ST_IDLE: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
        if (setup && !decode_err) begin
          read_en_d  = ~apb.pwrite;
          write_en_d = apb.pwrite;
        end else if (setup) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (!apb.psel) begin
          read_en_d  = 1'b0;
          write_en_d = 1'b0;
        end else if (reg_ready) begin
          read_en_d  = 1'b0;
          write_en_d = 1'b0;
          pready_d   = 1'b1;
          pslverr_d  = reg_err;
          prdata_d   = is_write_q ? '0 : rdata;
        end else if (cnt_done) begin
          read_en_d  = 1'b0;
          write_en_d = 1'b0;
          pready_d   = 1'b1;
          pslverr_d  = 1'b1;
        end
      end
      default: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_cmsdk_apb4_eg_slave_ws_interface.sv
// Self-checking bench for the APB4 wait-state slave front-end.
module tb_cmsdk_apb4_eg_slave_ws_interface;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          pclk = 1'b0;
  logic          presetn;
  logic [AW-1:0] addr;
  logic          read_en, write_en;
  logic [SW-1:0] byte_strobe;
  logic [DW-1:0] wdata, rdata;
  logic          reg_ready, reg_err;

  always #5 pclk = ~pclk;

  cmsdk_apb4_eg_slave_ws_interface_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) apb ();

  cmsdk_apb4_eg_slave_ws_interface #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .ADDR_MAX('h7FF), .TIMEOUT(16), .PROT_CHECK(1'b1)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .apb         (apb),
    .addr        (addr),
    .read_en     (read_en),
    .write_en    (write_en),
    .byte_strobe (byte_strobe),
    .wdata       (wdata),
    .rdata       (rdata),
    .reg_ready   (reg_ready),
    .reg_err     (reg_err)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [SW-1:0] st;
    logic [2:0]    prot;
    int            dly;       // enable cycle in which reg_ready is given, 0 = never
    logic [DW-1:0] rd;
    logic          rerr;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    int            exp_lat;   // cycle (setup = 1) in which pready is seen
    int            exp_en;
    int            exp_commit;
  } vec_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t sbq[$];
  vec_t  vt[10];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [SW-1:0] st, input logic [2:0] prot, input int dly,
                              input logic [DW-1:0] rd, input logic rerr, input logic exp_err,
                              input logic [DW-1:0] exp_rd, input int exp_lat, input int exp_en,
                              input int exp_commit);
    vec_t v;
    v.wr = wr; v.a = a; v.wd = wd; v.st = st; v.prot = prot; v.dly = dly; v.rd = rd;
    v.rerr = rerr; v.exp_err = exp_err; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
    v.exp_en = exp_en; v.exp_commit = exp_commit;
    return v;
  endfunction

  // Drive one transfer starting now (just after a rising edge), act as the
  // register side, and score the response.  Leaves psel low one cycle later.
  task automatic run_xfer(input int id, input vec_t v);
    int    cyc, en_cnt, commits;
    bit    done;
    resp_t r;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = v.wr;
    apb.paddr   = v.a;
    apb.pwdata  = v.wd;
    apb.pstrb   = v.st;
    apb.pprot   = v.prot;
    rdata       = v.rd;
    reg_err     = v.rerr;
    reg_ready   = 1'b0;
    sbq.push_back('{err: v.exp_err, data: v.exp_rd});
    cyc = 1; en_cnt = 0; commits = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
      apb.penable = 1'b1;
      reg_ready   = 1'b0;
      if (read_en || write_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          chk($sformatf("v%0d_read_en", id), read_en, !v.wr);
          chk($sformatf("v%0d_write_en", id), write_en, v.wr);
          chk($sformatf("v%0d_addr", id), addr, v.a);
          if (v.wr) begin
            chk($sformatf("v%0d_wdata", id), wdata, v.wd);
            chk($sformatf("v%0d_strobe", id), byte_strobe, v.st);
          end
        end
        if (v.dly != 0 && en_cnt == v.dly) begin
          reg_ready = 1'b1;
          if (write_en) commits++;
        end
      end
      if (apb.pready) begin
        done = 1'b1;
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_unexpected_pready", id), 1, 0);
        end else begin
          r = sbq.pop_front();
          chk($sformatf("v%0d_pslverr", id), apb.pslverr, r.err);
          chk($sformatf("v%0d_prdata", id), apb.prdata, r.data);
        end
      end
    end
    if (!done) begin
      chk($sformatf("v%0d_pready_timeout", id), 0, 1);
      sbq.delete();
    end
    chk($sformatf("v%0d_latency", id), cyc, v.exp_lat);
    chk($sformatf("v%0d_en_cycles", id), en_cnt, v.exp_en);
    chk($sformatf("v%0d_commits", id), commits, v.exp_commit);
    chk($sformatf("v%0d_sb_empty", id), sbq.size(), 0);
    @(posedge pclk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    reg_ready   = 1'b0;
    chk($sformatf("v%0d_pready_drop", id), apb.pready, 0);
    chk($sformatf("v%0d_pslverr_drop", id), apb.pslverr, 0);
    chk($sformatf("v%0d_prdata_drop", id), apb.prdata, 0);
    chk($sformatf("v%0d_en_drop", id), read_en | write_en, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"}, apb.pready, 0);
    chk({tag, "_pslverr"}, apb.pslverr, 0);
    chk({tag, "_prdata"}, apb.prdata, 0);
    chk({tag, "_read_en"}, read_en, 0);
    chk({tag, "_write_en"}, write_en, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_strobe"}, byte_strobe, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=expired required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn     = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    apb.pprot   = '0;
    rdata       = '0;
    reg_ready   = 1'b0;
    reg_err     = 1'b0;

    //            wr  addr    wdata         strb  prot    dly rdata         rerr eerr erdata       lat en cm
    vt[0] = mk(1'b1, 'h100, 32'hA5A5_5A5A, 4'hF, 3'b000, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,         3,  1, 1);
    vt[1] = mk(1'b0, 'h004, 32'h0,         4'h0, 3'b000, 4, 32'h1234_5678, 0, 0, 32'h1234_5678, 6,  4, 0);
    vt[2] = mk(1'b0, 'h008, 32'h0,         4'h0, 3'b000, 0, 32'h9999_9999, 0, 1, 32'h0,         18, 16, 0);
    vt[3] = mk(1'b1, 'h002, 32'h1111_2222, 4'hF, 3'b000, 0, 32'h0,         0, 1, 32'h0,         2,  0, 0);
    vt[4] = mk(1'b1, 'h800, 32'h3333_4444, 4'hF, 3'b000, 0, 32'h0,         0, 1, 32'h0,         2,  0, 0);
    vt[5] = mk(1'b1, 'h104, 32'h5555_6666, 4'hF, 3'b010, 0, 32'h0,         0, 1, 32'h0,         2,  0, 0);
    vt[6] = mk(1'b0, 'h00C, 32'h0,         4'h0, 3'b000, 2, 32'hDEAD_BEEF, 1, 1, 32'hDEAD_BEEF, 4,  2, 0);
    vt[7] = mk(1'b0, 'h010, 32'h0,         4'h0, 3'b000, 1, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D, 3,  1, 0);
    vt[8] = mk(1'b0, 'h020, 32'h0,         4'h0, 3'b010, 1, 32'h0000_55AA, 0, 0, 32'h0000_55AA, 3,  1, 0);
    vt[9] = mk(1'b1, 'h7FC, 32'hCAFE_0001, 4'h3, 3'b000, 3, 32'h7777_7777, 1, 1, 32'h0,         5,  3, 1);

    repeat (2) @(posedge pclk);
    #1;
    chk_all_zero("reset");
    @(negedge pclk) presetn = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 8; i++) run_xfer(i, vt[i]);

    // psel dropped while the request is outstanding: no response, enables drop
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 'h00C; apb.pprot = '0;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    chk("abort_req_read_en", read_en, 1);
    @(posedge pclk); #1;
    chk("abort_still_req", read_en, 1);
    apb.psel = 1'b0; apb.penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk($sformatf("abort_c%0d_read_en", i), read_en, 0);
      chk($sformatf("abort_c%0d_pready", i), apb.pready, 0);
    end

    // reset asserted in the middle of a write request
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 'h010;
    apb.pwdata = 32'h1111_0000; apb.pstrb = 4'hF;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    chk("rst_req_write_en", write_en, 1);
    presetn = 1'b0;
    #1;
    chk_all_zero("rst_in_req");
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge pclk) presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk($sformatf("rst_c%0d_pready", i), apb.pready, 0);
      chk($sformatf("rst_c%0d_write_en", i), write_en, 0);
    end

    for (int i = 8; i < 10; i++) run_xfer(i, vt[i]);

    chk("final_sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
